spi_arbiter: RTL and testbench

Round-robin arbiter that shares the single SPI master instance between two SPI clients. Examples of clients are the RTC controller and a second peripheral controller on the same SCK/MOSI/MISO wires. The arbiter owns one active-low chip select per client and grants whole multi-byte transactions. It routes each client's start/data to the master and returns busy/new_data only to the current owner. It sits between the client FSMs and the `spi` module.

---
 rtl/spi_arbiter.sv | 152 +++++++++++++++
 tb/tb_spi_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter
// Round-robin arbiter sharing one SPI master between two clients. A grant
// covers a whole multi-byte transaction: it is taken in IDLE, held through
// ACTIVE while the owner keeps req high, held through DRAIN until the master
// goes idle, then released for GAP cycles with every chip select deasserted.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req[1:0]             per-client transaction request (level)
//   c_start[1:0]         per-client byte start strobe
//   c_data_in0/1         per-client transmit byte
//   gnt[1:0]             one-hot registered grant (00 = no owner)
//   c_busy[1:0]          per-client busy (non-owner always busy)
//   c_new_data[1:0]      received-byte strobe, owner only
//   c_data_out           received byte, broadcast
//   cs_n[1:0]            registered active-low chip selects
//   m_start, m_data_in   to the SPI master
//   m_busy, m_new_data,
//   m_data_out           from the SPI master
module spi_arbiter #(
  parameter int unsigned GAP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] c_start,
  input  logic [7:0] c_data_in0,
  input  logic [7:0] c_data_in1,
  output logic [1:0] gnt,
  output logic [1:0] c_busy,
  output logic [1:0] c_new_data,
  output logic [7:0] c_data_out,
  output logic [1:0] cs_n,
  output logic       m_start,
  output logic [7:0] m_data_in,
  input  logic       m_busy,
  input  logic       m_new_data,
  input  logic [7:0] m_data_out
);

  localparam int unsigned NCLI  = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NCLI-1:0]   gnt_q, gnt_d;
  logic [NCLI-1:0]   cs_n_q, cs_n_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;

  // Index of the current owner; only meaningful while gnt_q is non-zero.
  logic              own_idx;
  logic              has_owner;
  logic              win_idx;

  assign own_idx   = gnt_q[1];
  assign has_owner = |gnt_q;

  // State register; reset drives chip selects high without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= NCLI'(0);
      cs_n_q    <= {NCLI{1'b1}};
      ptr_q     <= 1'b0;
      gap_cnt_q <= CNT_W'(0);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cs_n_q    <= cs_n_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Arbitration and transaction-lifetime sequencing.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cs_n_d    = cs_n_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    win_idx   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != NCLI'(0)) begin
          // Contention resolved by the pointer; a lone requester always wins.
          win_idx   = (req == 2'b11) ? ptr_q : req[1];
          gnt_d     = win_idx ? 2'b10 : 2'b01;
          cs_n_d    = win_idx ? 2'b01 : 2'b10;
          ptr_d     = ~win_idx;
          state_d   = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (!req[own_idx]) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Keep the device selected until the in-flight byte completes.
        if (!m_busy) begin
          gnt_d     = NCLI'(0);
          cs_n_d    = {NCLI{1'b1}};
          gap_cnt_d = CNT_W'(0);
          state_d   = ST_GAP;
        end
      end

      ST_GAP: begin
        gap_cnt_d = CNT_W'(gap_cnt_q + CNT_W'(1));
        if (gap_cnt_q == CNT_W'(GAP - 1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = NCLI'(0);
        cs_n_d  = {NCLI{1'b1}};
      end
    endcase
  end

  // Zero-latency datapath; starts pass only from the owner while ACTIVE, so a
  // start coinciding with the falling req is dropped along with req itself.
  always_comb begin
    m_start   = 1'b0;
    m_data_in = DW'(0);
    if (has_owner) begin
      m_data_in = own_idx ? c_data_in1 : c_data_in0;
      m_start   = (state_q == ST_ACTIVE) & c_start[own_idx] & req[own_idx] & ~m_busy;
    end
  end

  assign c_busy     = ~gnt_q | {NCLI{m_busy}};
  assign c_new_data = gnt_q & {NCLI{m_new_data}};
  assign c_data_out = m_data_out;
  assign gnt        = gnt_q;
  assign cs_n       = cs_n_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small behavioural SPI master model.
module tb_spi_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] c_start;
  logic [7:0] c_data_in0;
  logic [7:0] c_data_in1;
  logic [1:0] gnt;
  logic [1:0] c_busy;
  logic [1:0] c_new_data;
  logic [7:0] c_data_out;
  logic [1:0] cs_n;
  logic       m_start;
  logic [7:0] m_data_in;
  logic       m_busy     = 1'b0;
  logic       m_new_data = 1'b0;
  logic [7:0] m_data_out;

  int checks   = 0;
  int failures = 0;
  int m_len    = 3;
  int m_cnt    = 0;
  int m_xfers  = 0;
  int nd_cnt [2];

  spi_arbiter #(.GAP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .c_start    (c_start),
    .c_data_in0 (c_data_in0),
    .c_data_in1 (c_data_in1),
    .gnt        (gnt),
    .c_busy     (c_busy),
    .c_new_data (c_new_data),
    .c_data_out (c_data_out),
    .cs_n       (cs_n),
    .m_start    (m_start),
    .m_data_in  (m_data_in),
    .m_busy     (m_busy),
    .m_new_data (m_new_data),
    .m_data_out (m_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_data_out = 8'hA5;

  // Master model: busy for m_len cycles per byte, then one new_data pulse.
  always @(posedge clk) begin
    m_new_data <= 1'b0;
    if (!m_busy && m_start) begin
      m_busy  <= 1'b1;
      m_cnt   <= m_len;
      m_xfers <= m_xfers + 1;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy     <= 1'b0;
        m_new_data <= 1'b1;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Received-byte strobes seen by each client.
  initial begin
    nd_cnt[0] = 0;
    nd_cnt[1] = 0;
  end
  always @(negedge clk) begin
    if (c_new_data[0]) nd_cnt[0] = nd_cnt[0] + 1;
    if (c_new_data[1]) nd_cnt[1] = nd_cnt[1] + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input int c, input logic [7:0] d);
    if (c == 0) c_data_in0 = d;
    else        c_data_in1 = d;
  endtask

  // One byte from client c; returns at the negedge where its new_data is seen.
  task automatic send_byte(input int c, input logic [7:0] d);
    logic got;
    @(negedge clk);
    c_start    = 2'b00;
    c_start[c] = 1'b1;
    set_data(c, d);
    #1;
    check_eq("byte_start", 32'(m_start), 32'd1);
    check_eq("byte_mdata", 32'(m_data_in), 32'(d));
    check_eq("byte_csn", 32'(cs_n[c]), 32'd0);
    @(negedge clk);
    c_start = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (c_new_data[c]) begin
        got = 1'b1;
        check_eq("byte_rx", 32'(c_data_out), 32'hA5);
      end else begin
        @(negedge clk);
      end
    end
    check_eq("byte_rx_seen", 32'(got), 32'd1);
  endtask

  // Counts idle negedges (and those with all cs_n high) until a grant appears.
  task automatic wait_grant(output int cycles, output int highs);
    cycles = 0;
    highs  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) break;
      cycles = cycles + 1;
      if (cs_n == 2'b11) highs = highs + 1;
    end
  endtask

  int xf, nd0, nd1, cyc, hi, bcnt, bad;

  initial begin
    rst_n      = 1'b0;
    req        = 2'b00;
    c_start    = 2'b00;
    c_data_in0 = 8'h00;
    c_data_in1 = 8'h00;

    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req        = 2'($urandom);
      c_start    = 2'($urandom);
      c_data_in0 = 8'($urandom);
      c_data_in1 = 8'($urandom);
      #1;
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_csn", 32'(cs_n), 32'h3);
      check_eq("rst_mstart", 32'(m_start), 32'd0);
    end
    c_start = 2'b00;
    req     = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests: client 0 first, then client 1 after the gap.
    @(negedge clk);
    check_eq("sim_gnt0", 32'(gnt), 32'h1);
    check_eq("sim_csn0", 32'(cs_n), 32'h2);
    check_eq("sim_busy1", 32'(c_busy[1]), 32'd1);
    send_byte(0, 8'h11);
    @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    check_eq("sim_drain_gnt", 32'(gnt), 32'h1);
    check_eq("sim_drain_csn", 32'(cs_n), 32'h2);
    wait_grant(cyc, hi);
    check_eq("sim_gnt1", 32'(gnt), 32'h2);
    check_eq("sim_gap_cycles", 32'(cyc), 32'd5);
    check_eq("sim_gap_high", 32'(hi), 32'd5);
    send_byte(1, 8'h22);
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    req = 2'b11;
    wait_grant(cyc, hi);
    check_eq("sim_round3_gnt", 32'(gnt), 32'h1);
    check_eq("sim_round3_wait", 32'(cyc), 32'd4);
    req = 2'b00;
    repeat (10) @(negedge clk);
    check_eq("sim_idle_csn", 32'(cs_n), 32'h3);

    // Single client burst with a non-owner start in the middle.
    req = 2'b01;
    @(posedge clk);
    #1;
    check_eq("one_gnt", 32'(gnt), 32'h1);
    nd0 = nd_cnt[0];
    nd1 = nd_cnt[1];
    xf  = m_xfers;
    send_byte(0, 8'h0F);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    @(negedge clk);
    c_data_in0 = 8'h3C;
    c_data_in1 = 8'h8F;
    c_start    = 2'b10;
    #1;
    check_eq("nonown_mstart", 32'(m_start), 32'd0);
    check_eq("nonown_mdata", 32'(m_data_in), 32'h3C);
    check_eq("nonown_busy1", 32'(c_busy[1]), 32'd1);
    check_eq("nonown_busy0", 32'(c_busy[0]), 32'd0);
    @(negedge clk);
    c_start = 2'b00;
    repeat (3) @(negedge clk);
    check_eq("one_xfers", 32'(m_xfers - xf), 32'd3);
    check_eq("one_nd0", 32'(nd_cnt[0] - nd0), 32'd3);
    check_eq("one_nd1", 32'(nd_cnt[1] - nd1), 32'd0);
    check_eq("one_csn", 32'(cs_n), 32'h2);

    // Release while the master is still busy; client 1 waits behind it.
    req   = 2'b11;
    m_len = 8;
    nd0   = nd_cnt[0];
    @(negedge clk);
    c_start    = 2'b01;
    c_data_in0 = 8'hB7;
    #1;
    check_eq("rel_mstart", 32'(m_start), 32'd1);
    @(negedge clk);
    c_start = 2'b00;
    req     = 2'b10;
    bcnt = 0;
    bad  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!m_busy) break;
      bcnt = bcnt + 1;
      if (cs_n != 2'b10 || gnt != 2'b01) bad = bad + 1;
    end
    check_eq("rel_busy_cycles", 32'(bcnt), 32'd7);
    check_eq("rel_held", 32'(bad), 32'd0);
    check_eq("rel_csn_last", 32'(cs_n), 32'h2);
    @(negedge clk);
    check_eq("rel_csn_up", 32'(cs_n), 32'h3);
    check_eq("rel_gnt_clr", 32'(gnt), 32'h0);
    check_eq("rel_nd0", 32'(nd_cnt[0] - nd0), 32'd1);
    wait_grant(cyc, hi);
    check_eq("rel_gnt1", 32'(gnt), 32'h2);
    check_eq("rel_wait", 32'(cyc), 32'd4);
    m_len = 3;

    // Start coinciding with the falling req is suppressed; late req waits.
    xf = m_xfers;
    @(negedge clk);
    req        = 2'b00;
    c_start    = 2'b10;
    c_data_in1 = 8'h55;
    #1;
    check_eq("sup_mstart", 32'(m_start), 32'd0);
    @(negedge clk);
    c_start = 2'b00;
    check_eq("late_drain_csn", 32'(cs_n), 32'h1);
    @(negedge clk);
    check_eq("late_gap_csn", 32'(cs_n), 32'h3);
    @(negedge clk);
    req = 2'b01;
    wait_grant(cyc, hi);
    check_eq("late_gnt", 32'(gnt), 32'h1);
    check_eq("late_wait", 32'(cyc), 32'd3);
    check_eq("late_high", 32'(hi), 32'd3);
    check_eq("sup_xfers", 32'(m_xfers - xf), 32'd0);

    // Asynchronous reset in the middle of a byte.
    @(negedge clk);
    c_start    = 2'b01;
    c_data_in0 = 8'hC3;
    @(negedge clk);
    c_start = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_csn", 32'(cs_n), 32'h3);
    check_eq("arst_gnt", 32'(gnt), 32'h0);
    check_eq("arst_mstart", 32'(m_start), 32'd0);
    nd0 = nd_cnt[0];
    nd1 = nd_cnt[1];
    for (int i = 0; i < 20 && m_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("arst_nd0", 32'(nd_cnt[0] - nd0), 32'd0);
    check_eq("arst_nd1", 32'(nd_cnt[1] - nd1), 32'd0);
    req = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_ptr_gnt", 32'(gnt), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
